adc_ddr_capture_train: RTL and testbench



---
 rtl/adc_capture_pkg.sv | 28 ++
 rtl/sync_fifo_fwft.sv | 78 +++++++
 rtl/adc_ddr_capture_train.sv | 215 +++++++++++++++++++++
 tb/tb_adc_ddr_capture_train.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_capture_pkg.sv
// Shared types and constants for the ADC DDR capture and IDELAY training block.
package adc_capture_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LOAD   = 3'd1,
      ST_SETTLE = 3'd2,
      ST_CHECK  = 3'd3,
      ST_NEXT   = 3'd4,
      ST_CENTER = 3'd5,
      ST_STREAM = 3'd6
   } state_e;

   localparam logic [11:0] DEF_PATTERN = 12'hAAA;
   localparam int          OVF_W       = 16;

   // Saturating increment for the drop counter.
   function automatic logic [OVF_W-1:0] sat_inc(input logic [OVF_W-1:0] v);
      logic [OVF_W-1:0] r;
      if (v == {OVF_W{1'b1}}) begin
         r = v;
      end else begin
         r = v + OVF_W'(1);
      end
      return r;
   endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// Single-clock first-word-fall-through FIFO with a registered head word that
// holds its last value while empty.
module sync_fifo_fwft #(
   parameter int WIDTH = 13,
   parameter int DEPTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush_i,
   input  logic             wr_en_i,
   input  logic [WIDTH-1:0] wr_data_i,
   input  logic             rd_ready_i,
   output logic             rd_valid_o,
   output logic [WIDTH-1:0] rd_data_o,
   output logic             full_o
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [0:DEPTH-1];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q, wr_ptr_d, rd_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic             valid_q;
   logic [WIDTH-1:0] data_q, head_d;
   logic             rd_en_s, wr_ok_s, full_s;

   // Next-state pointers, occupancy and head word.
   always_comb begin
      full_s   = (count_q == (AW+1)'(DEPTH));
      rd_en_s  = rd_ready_i && valid_q;
      wr_ok_s  = wr_en_i && (!full_s || rd_en_s);
      count_d  = count_q + {{AW{1'b0}}, wr_ok_s} - {{AW{1'b0}}, rd_en_s};
      rd_ptr_d = rd_ptr_q + {{(AW-1){1'b0}}, rd_en_s};
      wr_ptr_d = wr_ptr_q + {{(AW-1){1'b0}}, wr_ok_s};
      // A word written this cycle into the next head slot bypasses the array.
      if (count_d == (AW+1)'(0)) begin
         head_d = data_q;
      end else if (wr_ok_s && (wr_ptr_q == rd_ptr_d)) begin
         head_d = wr_data_i;
      end else begin
         head_d = mem_q[rd_ptr_d];
      end
   end

   // Storage array write port.
   always_ff @(posedge clk) begin
      if (wr_ok_s && !flush_i) begin
         mem_q[wr_ptr_q] <= wr_data_i;
      end
   end

   // Pointers, occupancy and registered output word.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= {AW{1'b0}};
         rd_ptr_q <= {AW{1'b0}};
         count_q  <= {(AW+1){1'b0}};
         valid_q  <= 1'b0;
         data_q   <= {WIDTH{1'b0}};
      end else if (flush_i) begin
         wr_ptr_q <= {AW{1'b0}};
         rd_ptr_q <= {AW{1'b0}};
         count_q  <= {(AW+1){1'b0}};
         valid_q  <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         valid_q  <= (count_d != (AW+1)'(0));
         data_q   <= head_d;
      end
   end

   assign rd_valid_o = valid_q;
   assign rd_data_o  = data_q;
   assign full_o     = full_s;

endmodule

// File: rtl/adc_ddr_capture_train.sv
// DDR ADC capture with IDELAY tap-sweep training, window centring and a
// FWFT AXI-Stream output buffer with overflow accounting.
module adc_ddr_capture_train
   import adc_capture_pkg::*;
#(
   parameter int                 LANES      = 6,
   parameter int                 TAP_W      = 5,
   parameter logic [2*LANES-1:0] PATTERN    = DEF_PATTERN,
   parameter int                 SETTLE_CYC = 16,
   parameter int                 CHECK_LEN  = 64,
   parameter int                 MIN_WIN    = 4,
   parameter int                 DEF_TAP    = 19,
   parameter int                 FIFO_DEPTH = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [LANES-1:0]   iddr_q1,
   input  logic [LANES-1:0]   iddr_q2,
   input  logic               adc_or,
   input  logic               train_start,
   output logic [TAP_W-1:0]   dly_cntvalue,
   output logic               dly_ld,
   output logic               train_done,
   output logic               train_fail,
   output logic [2*LANES:0]   m_tdata,
   output logic               m_tvalid,
   input  logic               m_tready,
   output logic               overflow,
   output logic [OVF_W-1:0]   ovf_count
);

   localparam int                SW       = 2 * LANES;
   localparam int                LEN_W    = TAP_W + 1;
   localparam int                CNT_W    = 16;
   localparam logic [TAP_W-1:0]  TAP_LAST = {TAP_W{1'b1}};

   state_e             state_q;
   logic [SW-1:0]      sample_q, prev_q;
   logic               or_q;
   logic [TAP_W-1:0]   tap_q, cur_start_q, best_start_q;
   logic [LEN_W-1:0]   cur_len_q, best_len_q;
   logic [CNT_W-1:0]   cnt_q;
   logic               pass_q, dly_ld_q, done_q, fail_q, ovf_flag_q;
   logic [OVF_W-1:0]   ovf_cnt_q;

   logic               sample_ok_s, closing_s, drop_s;
   logic               fifo_wr_s, fifo_flush_s, fifo_full_s, fifo_valid_s;
   logic [LEN_W-1:0]   new_len_s, close_len_s;
   logic [TAP_W-1:0]   new_start_s, close_start_s, center_tap_s;

   // IDDR outputs and over-range flag, one register stage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sample_q <= {SW{1'b0}};
         or_q     <= 1'b0;
      end else begin
         sample_q <= {iddr_q1, iddr_q2};
         or_q     <= adc_or;
      end
   end

   // Per-sample pass test, run bookkeeping and stream-side control.
   always_comb begin
      sample_ok_s = ((sample_q == PATTERN) || (sample_q == ~PATTERN)) &&
                    ((cnt_q == CNT_W'(0)) || (sample_q != prev_q));
      new_len_s   = cur_len_q + LEN_W'(1);
      if (cur_len_q == LEN_W'(0)) begin
         new_start_s = tap_q;
      end else begin
         new_start_s = cur_start_q;
      end
      // The last tap always closes a run so a window ending there is kept.
      closing_s     = !pass_q || (tap_q == TAP_LAST);
      close_len_s   = pass_q ? new_len_s : cur_len_q;
      close_start_s = pass_q ? new_start_s : cur_start_q;
      center_tap_s  = best_start_q + best_len_q[LEN_W-1:1];
      fifo_wr_s     = (state_q == ST_STREAM) && !train_start;
      fifo_flush_s  = (state_q == ST_STREAM) && train_start;
      drop_s        = fifo_wr_s && fifo_full_s && !(m_tready && fifo_valid_s);
   end

   // Training / streaming state machine with registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         tap_q        <= {TAP_W{1'b0}};
         cur_start_q  <= {TAP_W{1'b0}};
         best_start_q <= {TAP_W{1'b0}};
         cur_len_q    <= {LEN_W{1'b0}};
         best_len_q   <= {LEN_W{1'b0}};
         cnt_q        <= {CNT_W{1'b0}};
         prev_q       <= {SW{1'b0}};
         pass_q       <= 1'b0;
         dly_ld_q     <= 1'b0;
         done_q       <= 1'b0;
         fail_q       <= 1'b0;
         ovf_flag_q   <= 1'b0;
         ovf_cnt_q    <= {OVF_W{1'b0}};
      end else begin
         dly_ld_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (train_start) begin
                  tap_q        <= {TAP_W{1'b0}};
                  cur_len_q    <= {LEN_W{1'b0}};
                  cur_start_q  <= {TAP_W{1'b0}};
                  best_len_q   <= {LEN_W{1'b0}};
                  best_start_q <= {TAP_W{1'b0}};
                  done_q       <= 1'b0;
                  fail_q       <= 1'b0;
                  state_q      <= ST_LOAD;
               end
            end
            ST_LOAD: begin
               dly_ld_q <= 1'b1;
               cnt_q    <= {CNT_W{1'b0}};
               state_q  <= ST_SETTLE;
            end
            ST_SETTLE: begin
               if (cnt_q == CNT_W'(SETTLE_CYC - 1)) begin
                  cnt_q   <= {CNT_W{1'b0}};
                  pass_q  <= 1'b1;
                  state_q <= ST_CHECK;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            ST_CHECK: begin
               if (!sample_ok_s) begin
                  pass_q <= 1'b0;
               end
               prev_q <= sample_q;
               if (cnt_q == CNT_W'(CHECK_LEN - 1)) begin
                  cnt_q   <= {CNT_W{1'b0}};
                  state_q <= ST_NEXT;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            ST_NEXT: begin
               // Strictly-longer comparison lets the earliest run win ties.
               if (closing_s && (close_len_s > best_len_q)) begin
                  best_len_q   <= close_len_s;
                  best_start_q <= close_start_s;
               end
               cur_len_q   <= pass_q ? new_len_s : {LEN_W{1'b0}};
               cur_start_q <= new_start_s;
               if (tap_q == TAP_LAST) begin
                  state_q <= ST_CENTER;
               end else begin
                  tap_q   <= tap_q + TAP_W'(1);
                  state_q <= ST_LOAD;
               end
            end
            ST_CENTER: begin
               if (best_len_q >= LEN_W'(MIN_WIN)) begin
                  tap_q  <= center_tap_s;
                  done_q <= 1'b1;
               end else begin
                  tap_q  <= TAP_W'(DEF_TAP);
                  fail_q <= 1'b1;
               end
               dly_ld_q <= 1'b1;
               state_q  <= ST_STREAM;
            end
            ST_STREAM: begin
               if (train_start) begin
                  tap_q        <= {TAP_W{1'b0}};
                  cur_len_q    <= {LEN_W{1'b0}};
                  cur_start_q  <= {TAP_W{1'b0}};
                  best_len_q   <= {LEN_W{1'b0}};
                  best_start_q <= {TAP_W{1'b0}};
                  done_q       <= 1'b0;
                  fail_q       <= 1'b0;
                  ovf_flag_q   <= 1'b0;
                  ovf_cnt_q    <= {OVF_W{1'b0}};
                  state_q      <= ST_LOAD;
               end else if (drop_s) begin
                  ovf_flag_q <= 1'b1;
                  ovf_cnt_q  <= sat_inc(ovf_cnt_q);
               end else begin
                  ovf_flag_q <= ovf_flag_q;
               end
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   sync_fifo_fwft #(
      .WIDTH (SW + 1),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush_i    (fifo_flush_s),
      .wr_en_i    (fifo_wr_s),
      .wr_data_i  ({or_q, sample_q}),
      .rd_ready_i (m_tready),
      .rd_valid_o (fifo_valid_s),
      .rd_data_o  (m_tdata),
      .full_o     (fifo_full_s)
   );

   assign dly_cntvalue = tap_q;
   assign dly_ld       = dly_ld_q;
   assign train_done   = done_q;
   assign train_fail   = fail_q;
   assign m_tvalid     = fifo_valid_s;
   assign overflow     = ovf_flag_q;
   assign ovf_count    = ovf_cnt_q;

endmodule

// File: tb/tb_adc_ddr_capture_train.sv
// Directed self-checking bench for adc_ddr_capture_train at default parameters.
module tb_adc_ddr_capture_train;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [5:0]  iddr_q1, iddr_q2;
   logic        adc_or;
   logic        train_start;
   logic [4:0]  dly_cntvalue;
   logic        dly_ld, train_done, train_fail;
   logic [12:0] m_tdata;
   logic        m_tvalid, m_tready;
   logic        overflow;
   logic [15:0] ovf_count;

   int errors = 0;
   int checks = 0;

   int          gen_mode = 0;
   int          win_lo = 8, win_hi = 20;
   logic        toggle = 1'b0;
   logic [11:0] ctr = 12'h000;
   logic [11:0] man_data = 12'h000;
   logic        man_or = 1'b0;

   logic [4:0]  ld_vals [0:63];
   int          ld_cnt;
   logic        timed_out;
   logic [12:0] pre_tdata, snap_tdata;
   logic        snap_valid;
   logic [18:0] snap_flags;

   adc_ddr_capture_train dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .iddr_q1      (iddr_q1),
      .iddr_q2      (iddr_q2),
      .adc_or       (adc_or),
      .train_start  (train_start),
      .dly_cntvalue (dly_cntvalue),
      .dly_ld       (dly_ld),
      .train_done   (train_done),
      .train_fail   (train_fail),
      .m_tdata      (m_tdata),
      .m_tvalid     (m_tvalid),
      .m_tready     (m_tready),
      .overflow     (overflow),
      .ovf_count    (ovf_count)
   );

   always #5 clk = ~clk;

   // ADC data source: tap-dependent checkerboard, counter, or manual words.
   initial begin
      logic [11:0] d;
      iddr_q1 = 6'h00;
      iddr_q2 = 6'h00;
      adc_or  = 1'b0;
      forever begin
         @(negedge clk);
         d = {iddr_q1, iddr_q2};
         case (gen_mode)
            0: begin
               if (int'(dly_cntvalue) >= win_lo && int'(dly_cntvalue) <= win_hi)
                  d = toggle ? 12'hAAA : 12'h555;
               else
                  d = 12'($urandom);
               toggle = ~toggle;
               adc_or = 1'b0;
            end
            1: begin
               d = ctr;
               ctr = ctr + 12'd1;
               adc_or = 1'b0;
            end
            default: begin
               d = man_data;
               adc_or = man_or;
            end
         endcase
         iddr_q1 = d[11:6];
         iddr_q2 = d[5:0];
      end
   end

   task automatic do_training(input int inject);
      @(negedge clk);
      pre_tdata   = m_tdata;
      train_start = 1'b1;
      ld_cnt      = 0;
      timed_out   = 1'b1;
      for (int i = 0; i < 6000; i++) begin
         @(negedge clk);
         train_start = (i == inject);
         if (i == 0) begin
            snap_valid = m_tvalid;
            snap_tdata = m_tdata;
            snap_flags = {train_done, train_fail, overflow, ovf_count};
         end
         if (dly_ld) begin
            if (ld_cnt < 64) ld_vals[ld_cnt] = dly_cntvalue;
            ld_cnt++;
         end
         if (train_done || train_fail) begin
            timed_out = 1'b0;
            break;
         end
      end
      train_start = 1'b0;
   endtask

   task automatic test_reset;
      rst_n = 1'b0; train_start = 1'b0; m_tready = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if ({dly_cntvalue, dly_ld, train_done, train_fail, m_tvalid, m_tdata, overflow, ovf_count} !== 39'd0) begin
         errors++;
         $display("FAIL reset_state: got %h expected 0",
                  {dly_cntvalue, dly_ld, train_done, train_fail, m_tvalid, m_tdata, overflow, ovf_count});
      end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_train_window;
      int bad = 0;
      gen_mode = 0; win_lo = 8; win_hi = 20;
      do_training(500);
      checks++;
      if (timed_out !== 1'b0 || ld_cnt !== 33) begin
         errors++; $display("FAIL window_pulses: got %0d (timeout %0b) expected 33", ld_cnt, timed_out);
      end
      for (int i = 0; i < 32; i++) if (ld_vals[i] !== 5'(i)) bad++;
      checks++;
      if (bad !== 0) begin errors++; $display("FAIL window_sweep_order: %0d taps out of order expected 0", bad); end
      checks++;
      if (ld_vals[32] !== 5'd14 || dly_cntvalue !== 5'd14) begin
         errors++; $display("FAIL window_center: got %0d/%0d expected 14", ld_vals[32], dly_cntvalue);
      end
      checks++;
      if ({train_done, train_fail} !== 2'b10) begin
         errors++; $display("FAIL window_flags: got %b expected 10", {train_done, train_fail});
      end
      repeat (2) @(negedge clk);
      checks++;
      if (m_tvalid !== 1'b1) begin errors++; $display("FAIL window_stream: got tvalid %b expected 1", m_tvalid); end
   endtask

   task automatic test_train_none;
      gen_mode = 0; win_lo = 40; win_hi = 0;
      do_training(-1);
      checks++;
      if (ld_cnt !== 33 || dly_cntvalue !== 5'd19 || ld_vals[32] !== 5'd19) begin
         errors++; $display("FAIL none_default_tap: got %0d pulses tap %0d expected 33 tap 19", ld_cnt, dly_cntvalue);
      end
      checks++;
      if ({train_done, train_fail} !== 2'b01) begin
         errors++; $display("FAIL none_flags: got %b expected 01", {train_done, train_fail});
      end
      repeat (2) @(negedge clk);
      checks++;
      if (m_tvalid !== 1'b1) begin errors++; $display("FAIL none_stream: got tvalid %b expected 1", m_tvalid); end
   endtask

   task automatic test_train_edge;
      gen_mode = 0; win_lo = 28; win_hi = 31;
      do_training(-1);
      checks++;
      if (dly_cntvalue !== 5'd30 || {train_done, train_fail} !== 2'b10) begin
         errors++; $display("FAIL edge_center: got tap %0d flags %b expected tap 30 flags 10",
                            dly_cntvalue, {train_done, train_fail});
      end
   endtask

   task automatic test_overflow;
      logic [12:0] rd [0:16];
      int bad = 0;
      m_tready = 1'b0;
      gen_mode = 0; win_lo = 8; win_hi = 20;
      do_training(-1);
      gen_mode = 1;
      checks++;
      if (snap_valid !== 1'b0 || snap_tdata !== pre_tdata) begin
         errors++; $display("FAIL flush_hold: got valid %b data %h expected valid 0 data %h",
                            snap_valid, snap_tdata, pre_tdata);
      end
      repeat (20) @(negedge clk);
      checks++;
      if ({m_tvalid, overflow, ovf_count} !== {1'b1, 1'b1, 16'd4}) begin
         errors++; $display("FAIL ovf_state: got valid %b ovf %b count %0d expected 1 1 4",
                            m_tvalid, overflow, ovf_count);
      end
      m_tready = 1'b1;
      for (int k = 0; k < 17; k++) begin
         if (m_tvalid !== 1'b1) bad++;
         rd[k] = m_tdata;
         @(negedge clk);
      end
      for (int k = 3; k < 16; k++) if (rd[k] !== rd[k-1] + 13'd1) bad++;
      checks++;
      if (bad !== 0) begin errors++; $display("FAIL ovf_order: %0d out-of-order words expected 0", bad); end
      checks++;
      if (rd[16] !== rd[15] + 13'd5) begin
         errors++; $display("FAIL ovf_drop_gap: got %h expected %h", rd[16], rd[15] + 13'd5);
      end
   endtask

   task automatic test_or_flag;
      int hits = 0;
      logic [12:0] hit_word = 13'd0;
      m_tready = 1'b1;
      gen_mode = 0; win_lo = 8; win_hi = 20;
      do_training(-1);
      checks++;
      if (snap_flags !== 19'd0) begin
         errors++; $display("FAIL restart_clear: got %h expected 0", snap_flags);
      end
      man_data = 12'h000; man_or = 1'b0;
      gen_mode = 2;
      for (int i = 0; i < 24; i++) begin
         @(negedge clk);
         if (m_tvalid && m_tdata[12]) begin hits++; hit_word = m_tdata; end
         man_data = 12'h100 + 12'(i);
         man_or   = (i == 5);
      end
      checks++;
      if (hits !== 1 || hit_word !== 13'h1105) begin
         errors++; $display("FAIL or_flag: got %0d hits word %h expected 1 hit word 1105", hits, hit_word);
      end
      man_or = 1'b0;
   endtask

   task automatic test_reset_mid;
      int n = 0;
      int ld_seen = 0;
      gen_mode = 0; win_lo = 8; win_hi = 20;
      @(negedge clk); train_start = 1'b1;
      @(negedge clk); train_start = 1'b0;
      for (int i = 0; i < 500 && n < 2; i++) begin
         @(negedge clk);
         if (dly_ld) n++;
      end
      repeat (40) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({dly_cntvalue, dly_ld, train_done, train_fail, m_tvalid, m_tdata, overflow, ovf_count} !== 39'd0 || n !== 2) begin
         errors++;
         $display("FAIL reset_mid_async: got %h (pulses %0d) expected 0 (pulses 2)",
                  {dly_cntvalue, dly_ld, train_done, train_fail, m_tvalid, m_tdata, overflow, ovf_count}, n);
      end
      repeat (5) begin @(negedge clk); if (dly_ld) ld_seen++; end
      rst_n = 1'b1;
      repeat (60) begin @(negedge clk); if (dly_ld) ld_seen++; end
      checks++;
      if (ld_seen !== 0 || dly_cntvalue !== 5'd0) begin
         errors++; $display("FAIL reset_mid_idle: got %0d pulses tap %0d expected 0 0", ld_seen, dly_cntvalue);
      end
      do_training(-1);
      checks++;
      if (ld_cnt !== 33 || ld_vals[0] !== 5'd0 || dly_cntvalue !== 5'd14) begin
         errors++; $display("FAIL reset_mid_restart: got %0d pulses first %0d final %0d expected 33 0 14",
                            ld_cnt, ld_vals[0], dly_cntvalue);
      end
   endtask

   initial begin
      rst_n = 1'b0; train_start = 1'b0; m_tready = 1'b1;
      test_reset();
      test_train_window();
      test_train_none();
      test_train_edge();
      test_overflow();
      test_or_flag();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
